i2c_slave_regfile: RTL and testbench

//  I2C target (slave) with an addressable bank of NUM_REGS 8-bit registers. Supports pointer-set,

---
 rtl/i2c_slave_regfile_pkg.sv | 30 +++
 rtl/i2c_slave_regfile_bus_sync.sv | 41 ++++
 rtl/i2c_slave_regfile.sv | 229 ++++++++++++++++++++++
 tb/tb_i2c_slave_regfile.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_slave_regfile_pkg.sv
// Shared types and constants for the I2C register-file target.
// FSM state encoding, bus-level bit meanings and byte framing constants.
package i2c_slave_regfile_pkg;

  typedef enum logic [3:0] {
    StIdle,
    StAddr,
    StAddrAck,
    StPtr,
    StPtrAck,
    StWdata,
    StWdataAck,
    StRdata,
    StRdataAck,
    StIgnore
  } state_e;

  localparam logic READ  = 1'b1;
  localparam logic WRITE = 1'b0;
  localparam logic ACK   = 1'b0;
  localparam logic NACK  = 1'b1;

  localparam int unsigned BitsPerByte = 8;

  // True once all eight data/address bits of a byte have been sampled.
  function automatic logic byte_done(input logic [3:0] bit_cnt);
    return bit_cnt == 4'(BitsPerByte);
  endfunction

endpackage

// File: rtl/i2c_slave_regfile_bus_sync.sv
// Two-flop synchronizers for SCL/SDA plus single-cycle edge, START and STOP pulses.
// Both lines reset to 1 so the idle bus never looks like an edge after reset.
module i2c_slave_regfile_bus_sync (
  input  logic clock,
  input  logic reset,
  input  logic scl,
  input  logic sda,
  output logic sda_level,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_det,
  output logic stop_det
);

  logic [1:0] scl_sync_q;
  logic [1:0] sda_sync_q;
  logic       scl_prev_q;
  logic       sda_prev_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      scl_sync_q <= 2'b11;
      sda_sync_q <= 2'b11;
      scl_prev_q <= 1'b1;
      sda_prev_q <= 1'b1;
    end else begin
      scl_sync_q <= {scl_sync_q[0], scl};
      sda_sync_q <= {sda_sync_q[0], sda};
      scl_prev_q <= scl_sync_q[1];
      sda_prev_q <= sda_sync_q[1];
    end
  end

  assign sda_level = sda_sync_q[1];
  assign scl_rise  = scl_sync_q[1] & ~scl_prev_q;
  assign scl_fall  = ~scl_sync_q[1] & scl_prev_q;
  // SDA transitions only count as START/STOP while SCL is stably high.
  assign start_det = scl_sync_q[1] & scl_prev_q & sda_prev_q & ~sda_sync_q[1];
  assign stop_det  = scl_sync_q[1] & scl_prev_q & ~sda_prev_q & sda_sync_q[1];

endmodule

// File: rtl/i2c_slave_regfile.sv
// I2C target with a bank of 8-bit registers, auto-incrementing pointer and a host-side port.
// The FSM advances on synced SCL falling edges; SDA is sampled on synced SCL rising edges.
module i2c_slave_regfile
  import i2c_slave_regfile_pkg::*;
#(
  parameter logic [6:0]  MY_ADDRESS = 7'h56,
  parameter int unsigned NUM_REGS   = 4,
  parameter logic [7:0]  REG_INIT   = 8'hA5,
  localparam int unsigned PTR_W     = $clog2(NUM_REGS)
) (
  input  logic             clock,
  input  logic             reset,
  inout  wire              SDA,
  input  logic             SCL,
  input  logic             host_we,
  input  logic [PTR_W-1:0] host_addr,
  input  logic [7:0]       host_wdata,
  output logic [7:0]       host_rdata,
  output logic             wr_strobe,
  output logic [PTR_W-1:0] wr_addr,
  output logic [7:0]       wr_data,
  output logic             busy
);

  logic sda_level, scl_rise, scl_fall, start_det, stop_det;

  i2c_slave_regfile_bus_sync u_bus_sync (
    .clock     (clock),
    .reset     (reset),
    .scl       (SCL),
    .sda       (SDA),
    .sda_level (sda_level),
    .scl_rise  (scl_rise),
    .scl_fall  (scl_fall),
    .start_det (start_det),
    .stop_det  (stop_det)
  );

  state_e           state_q, state_d;
  logic [7:0]       shift_q, shift_d;
  logic [3:0]       bit_cnt_q, bit_cnt_d;
  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic             rw_q, rw_d;
  logic             ack_q, ack_d;
  logic             sda_oe_q, sda_oe_d;
  logic             busy_q, busy_d;
  logic             wr_strobe_q, wr_strobe_d;
  logic [PTR_W-1:0] wr_addr_q, wr_addr_d;
  logic [7:0]       wr_data_q, wr_data_d;
  logic             commit;
  logic [7:0]       regs_q [NUM_REGS];

  logic [PTR_W-1:0] ptr_inc;
  logic             addr_match;

  assign ptr_inc    = ptr_q + PTR_W'(1);
  assign addr_match = shift_q[7:1] == MY_ADDRESS;

  // State register
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    if (start_det) begin
      state_d = StAddr;
    end else if (stop_det) begin
      state_d = StIdle;
    end else if (scl_fall) begin
      case (state_q)
        StAddr:     if (byte_done(bit_cnt_q)) state_d = addr_match ? StAddrAck : StIgnore;
        StAddrAck:  state_d = (rw_q == READ) ? StRdata : StPtr;
        StPtr:      if (byte_done(bit_cnt_q)) state_d = StPtrAck;
        StPtrAck:   state_d = StWdata;
        StWdata:    if (byte_done(bit_cnt_q)) state_d = StWdataAck;
        StWdataAck: state_d = StWdata;
        StRdata:    if (byte_done(bit_cnt_q)) state_d = StRdataAck;
        StRdataAck: state_d = (ack_q == ACK) ? StRdata : StIgnore;
        default:    state_d = state_q;
      endcase
    end
  end

  // Output and datapath logic
  always_comb begin
    shift_d     = shift_q;
    bit_cnt_d   = bit_cnt_q;
    ptr_d       = ptr_q;
    rw_d        = rw_q;
    ack_d       = ack_q;
    sda_oe_d    = sda_oe_q;
    busy_d      = busy_q;
    wr_strobe_d = 1'b0;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    commit      = 1'b0;
    if (start_det) begin
      bit_cnt_d = '0;
      sda_oe_d  = 1'b0;
    end else if (stop_det) begin
      bit_cnt_d = '0;
      sda_oe_d  = 1'b0;
      busy_d    = 1'b0;
    end else if (scl_rise) begin
      case (state_q)
        StAddr, StPtr, StWdata: begin
          shift_d   = {shift_q[6:0], sda_level};
          bit_cnt_d = bit_cnt_q + 4'd1;
        end
        StRdata:    bit_cnt_d = bit_cnt_q + 4'd1;
        StRdataAck: ack_d = sda_level;
        default:    ;
      endcase
    end else if (scl_fall) begin
      case (state_q)
        StAddr: begin
          if (byte_done(bit_cnt_q)) begin
            bit_cnt_d = '0;
            rw_d      = shift_q[0];
            sda_oe_d  = addr_match;
            busy_d    = addr_match;
          end
        end
        StAddrAck: begin
          bit_cnt_d = '0;
          sda_oe_d  = 1'b0;
          if (rw_q == READ) begin
            shift_d  = regs_q[ptr_q];
            sda_oe_d = ~regs_q[ptr_q][7];
          end
        end
        StPtr: begin
          if (byte_done(bit_cnt_q)) begin
            ptr_d     = shift_q[PTR_W-1:0];
            bit_cnt_d = '0;
            sda_oe_d  = 1'b1;
          end
        end
        StPtrAck:   sda_oe_d = 1'b0;
        StWdata: begin
          if (byte_done(bit_cnt_q)) begin
            bit_cnt_d = '0;
            sda_oe_d  = 1'b1;
          end
        end
        StWdataAck: begin
          sda_oe_d    = 1'b0;
          commit      = 1'b1;
          wr_strobe_d = 1'b1;
          wr_addr_d   = ptr_q;
          wr_data_d   = shift_q;
          ptr_d       = ptr_inc;
        end
        StRdata: begin
          if (byte_done(bit_cnt_q)) begin
            bit_cnt_d = '0;
            sda_oe_d  = 1'b0;
          end else begin
            // Present the next bit: open-drain, so a 1 is simply released.
            shift_d  = {shift_q[6:0], 1'b0};
            sda_oe_d = ~shift_q[6];
          end
        end
        StRdataAck: begin
          if (ack_q == ACK) begin
            ptr_d    = ptr_inc;
            shift_d  = regs_q[ptr_inc];
            sda_oe_d = ~regs_q[ptr_inc][7];
          end else begin
            sda_oe_d = 1'b0;
            busy_d   = 1'b0;
          end
        end
        default:    sda_oe_d = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      shift_q     <= '0;
      bit_cnt_q   <= '0;
      ptr_q       <= '0;
      rw_q        <= WRITE;
      ack_q       <= NACK;
      sda_oe_q    <= 1'b0;
      busy_q      <= 1'b0;
      wr_strobe_q <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
    end else begin
      shift_q     <= shift_d;
      bit_cnt_q   <= bit_cnt_d;
      ptr_q       <= ptr_d;
      rw_q        <= rw_d;
      ack_q       <= ack_d;
      sda_oe_q    <= sda_oe_d;
      busy_q      <= busy_d;
      wr_strobe_q <= wr_strobe_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
    end
  end

  // The I2C commit is assigned last so it wins a same-index collision with the host.
  always_ff @(posedge clock) begin
    if (reset) begin
      regs_q <= '{default: REG_INIT};
    end else begin
      if (host_we) regs_q[host_addr] <= host_wdata;
      if (commit) regs_q[ptr_q] <= shift_q;
    end
  end

  // Reset gates the drive directly so SDA is released in the reset cycle itself.
  assign SDA        = (sda_oe_q && !reset) ? 1'b0 : 1'bz;
  assign host_rdata = regs_q[host_addr];
  assign wr_strobe  = wr_strobe_q;
  assign wr_addr    = wr_addr_q;
  assign wr_data    = wr_data_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_i2c_slave_regfile.sv
// Directed bench for i2c_slave_regfile: bit-banged controller on an open-drain SDA with pullup.
// Each scenario task drives the bus and compares against hand-computed values.
module tb_i2c_slave_regfile;

  localparam int H = 5;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       scl   = 1'b1;
  logic       sda_low = 1'b0;
  logic       host_we = 1'b0;
  logic [1:0] host_addr = 2'd0;
  logic [7:0] host_wdata = 8'h00;
  logic [7:0] host_rdata;
  logic       wr_strobe;
  logic [1:0] wr_addr;
  logic [7:0] wr_data;
  logic       busy;
  wire        sda;

  pullup (sda);
  assign sda = sda_low ? 1'b0 : 1'bz;

  int checks = 0;
  int errors = 0;

  logic [7:0] s_data_q[$];
  logic [1:0] s_addr_q[$];

  i2c_slave_regfile #(
    .MY_ADDRESS (7'h56),
    .NUM_REGS   (4),
    .REG_INIT   (8'hA5)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .SDA        (sda),
    .SCL        (scl),
    .host_we    (host_we),
    .host_addr  (host_addr),
    .host_wdata (host_wdata),
    .host_rdata (host_rdata),
    .wr_strobe  (wr_strobe),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .busy       (busy)
  );

  always #5 clock = ~clock;

  always @(negedge clock) begin
    if (wr_strobe === 1'b1) begin
      s_data_q.push_back(wr_data);
      s_addr_q.push_back(wr_addr);
    end
  end

  task automatic wait_clks(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic bus_start();
    sda_low = 1'b1; wait_clks(H);
    scl = 1'b0;     wait_clks(H);
  endtask

  task automatic bus_rstart();
    sda_low = 1'b0; wait_clks(H);
    scl = 1'b1;     wait_clks(H);
    sda_low = 1'b1; wait_clks(H);
    scl = 1'b0;     wait_clks(H);
  endtask

  task automatic bus_stop();
    sda_low = 1'b1; wait_clks(H);
    scl = 1'b1;     wait_clks(H);
    sda_low = 1'b0; wait_clks(H);
  endtask

  task automatic send_bit(input logic b);
    sda_low = ~b; wait_clks(H);
    scl = 1'b1;   wait_clks(H);
    scl = 1'b0;   wait_clks(H);
  endtask

  task automatic read_bit(output logic b);
    sda_low = 1'b0; wait_clks(H);
    scl = 1'b1;     wait_clks(H);
    b = sda;
    scl = 1'b0;     wait_clks(H);
  endtask

  task automatic send_byte(input logic [7:0] d, output logic ack);
    for (int i = 7; i >= 0; i--) send_bit(d[i]);
    read_bit(ack);
  endtask

  task automatic read_byte(input logic ack, output logic [7:0] d);
    for (int i = 7; i >= 0; i--) read_bit(d[i]);
    send_bit(ack);
  endtask

  task automatic do_reset();
    reset = 1'b1; scl = 1'b1; sda_low = 1'b0;
    wait_clks(3);
    reset = 1'b0;
    wait_clks(3);
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (sda !== 1'b1) begin errors++; $display("FAIL reset_sda got %b want 1", sda); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++;
    if (wr_strobe !== 1'b0) begin errors++; $display("FAIL reset_strobe got %b want 0", wr_strobe); end
    for (int i = 0; i < 4; i++) begin
      host_addr = 2'(i); #1;
      checks++;
      if (host_rdata !== 8'hA5)
        begin errors++; $display("FAIL reset_reg%0d got %h want a5", i, host_rdata); end
    end
  endtask

  task automatic test_addr();
    logic ack;
    bus_start();
    send_byte(8'hAC, ack);
    checks++;
    if (ack !== 1'b0) begin errors++; $display("FAIL addr_match_ack got %b want 0", ack); end
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL addr_match_busy got %b want 1", busy); end
    bus_stop();
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL stop_busy got %b want 0", busy); end
    bus_start();
    send_byte(8'hAE, ack);
    checks++;
    if (ack !== 1'b1) begin errors++; $display("FAIL addr_miss_ack got %b want 1", ack); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL addr_miss_busy got %b want 0", busy); end
    bus_stop();
  endtask

  task automatic test_write();
    logic [7:0] bytes [4] = '{8'hAC, 8'h01, 8'h3C, 8'h7E};
    logic ack;
    int base = s_data_q.size();
    bus_start();
    for (int i = 0; i < 4; i++) begin
      send_byte(bytes[i], ack);
      checks++;
      if (ack !== 1'b0) begin errors++; $display("FAIL write_ack%0d got %b want 0", i, ack); end
    end
    bus_stop();
    checks++;
    if (s_data_q.size() - base !== 2)
      begin errors++; $display("FAIL write_strobes got %0d want 2", s_data_q.size() - base); end
    else begin
      checks++;
      if (s_addr_q[base] !== 2'd1 || s_data_q[base] !== 8'h3C)
        begin errors++; $display("FAIL write_strobe0 got %0d/%h want 1/3c",
                                 s_addr_q[base], s_data_q[base]); end
      checks++;
      if (s_addr_q[base+1] !== 2'd2 || s_data_q[base+1] !== 8'h7E)
        begin errors++; $display("FAIL write_strobe1 got %0d/%h want 2/7e",
                                 s_addr_q[base+1], s_data_q[base+1]); end
    end
    host_addr = 2'd1; #1;
    checks++;
    if (host_rdata !== 8'h3C) begin errors++; $display("FAIL write_reg1 got %h want 3c", host_rdata); end
    host_addr = 2'd2; #1;
    checks++;
    if (host_rdata !== 8'h7E) begin errors++; $display("FAIL write_reg2 got %h want 7e", host_rdata); end
  endtask

  task automatic read_pass(input logic [7:0] e0, input logic [7:0] e1, input logic [7:0] e2);
    logic ack;
    logic [7:0] d;
    logic [7:0] exp [3];
    exp[0] = e0; exp[1] = e1; exp[2] = e2;
    bus_start();
    send_byte(8'hAC, ack);
    send_byte(8'h03, ack);
    bus_rstart();
    send_byte(8'hAD, ack);
    checks++;
    if (ack !== 1'b0) begin errors++; $display("FAIL read_addr_ack got %b want 0", ack); end
    for (int i = 0; i < 3; i++) begin
      read_byte((i == 2) ? 1'b1 : 1'b0, d);
      checks++;
      if (d !== exp[i]) begin errors++; $display("FAIL read_byte%0d got %h want %h", i, d, exp[i]); end
    end
    checks++;
    if (sda !== 1'b1) begin errors++; $display("FAIL read_nack_release got %b want 1", sda); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL read_nack_busy got %b want 0", busy); end
    bus_stop();
  endtask

  task automatic host_write(input logic [1:0] a, input logic [7:0] d);
    host_addr = a; host_wdata = d; host_we = 1'b1;
    wait_clks(1);
    host_we = 1'b0;
  endtask

  task automatic test_read_wrap();
    do_reset();
    read_pass(8'hA5, 8'hA5, 8'hA5);
    host_write(2'd3, 8'h81);
    host_write(2'd0, 8'h42);
    host_write(2'd1, 8'hC3);
    read_pass(8'h81, 8'h42, 8'hC3);
  endtask

  task automatic test_collision();
    logic ack;
    bus_start();
    send_byte(8'hAC, ack);
    send_byte(8'h00, ack);
    for (int i = 7; i >= 0; i--) send_bit(1'(8'h22 >> i));
    sda_low = 1'b0; wait_clks(H);
    scl = 1'b1;     wait_clks(H);
    scl = 1'b0;
    // Two sync stages then the fall pulse: the commit lands on the third edge.
    @(posedge clock); @(posedge clock); #1;
    host_addr = 2'd0; host_wdata = 8'h11; host_we = 1'b1;
    @(posedge clock); #1;
    host_we = 1'b0;
    checks++;
    if (wr_strobe !== 1'b1) begin errors++; $display("FAIL coll_strobe got %b want 1", wr_strobe); end
    wait_clks(H);
    bus_stop();
    host_addr = 2'd0; #1;
    checks++;
    if (host_rdata !== 8'h22) begin errors++; $display("FAIL coll_reg0 got %h want 22", host_rdata); end
  endtask

  task automatic test_abort();
    logic ack;
    int base = s_data_q.size();
    bus_start();
    send_byte(8'hAC, ack);
    send_byte(8'h02, ack);
    send_bit(1'b0); send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
    bus_stop();
    checks++;
    if (s_data_q.size() !== base)
      begin errors++; $display("FAIL abort_strobe got %0d want %0d", s_data_q.size(), base); end
    host_addr = 2'd2; #1;
    checks++;
    if (host_rdata !== 8'hA5) begin errors++; $display("FAIL abort_reg2 got %h want a5", host_rdata); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy got %b want 0", busy); end
    // reg0 = 0x22, so the first read bit drives SDA low.
    bus_start();
    send_byte(8'hAC, ack);
    send_byte(8'h00, ack);
    bus_rstart();
    send_byte(8'hAD, ack);
    checks++;
    if (sda !== 1'b0) begin errors++; $display("FAIL midread_drive got %b want 0", sda); end
    reset = 1'b1;
    wait_clks(1);
    checks++;
    if (sda !== 1'b1) begin errors++; $display("FAIL midread_reset_sda got %b want 1", sda); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL midread_reset_busy got %b want 0", busy); end
    scl = 1'b1;
    wait_clks(2);
    reset = 1'b0;
    wait_clks(3);
  endtask

  initial begin
    test_reset();
    test_addr();
    test_write();
    test_read_wrap();
    test_collision();
    test_abort();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
